// File: rtl/ct_merge_pkg.sv
// Shared types and the round-robin pick helper for the ct merge/arbiter blocks.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package ct_merge_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } merge_state_t;

    // Widest requester count the pick helper handles; callers zero-extend.
    localparam int MAX_NI = 32;
    localparam int IDX_W  = 5;
    localparam int DBL_W  = 6;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] index;
    } rr_pick_t;

    // Round-robin pick: first set bit of valid[n-1:0] searching last+1,
    // last+2, ... modulo n. The request vector is laid out twice
    // back to back so the wrap is a plain window of a wider vector
    // (positions last+1 .. last+n) instead of a modulo.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_NI-1:0] valid,
        input logic [IDX_W-1:0]  last,
        input int                n
    );
        rr_pick_t             r;
        logic [2*MAX_NI-1:0]  dbl;
        logic [DBL_W-1:0]     hi;
        int                   lo_bound;
        int                   hi_bound;

        r   = '0;
        dbl = '0;
        for (int i = 0; i < MAX_NI; i++) begin
            if (i < n) begin
                hi                = DBL_W'(i + n);
                dbl[i[DBL_W-1:0]] = valid[i[IDX_W-1:0]];
                dbl[hi]           = valid[i[IDX_W-1:0]];
            end
        end

        lo_bound = int'(last) + 1;
        hi_bound = int'(last) + n;
        // Scan downward so the lowest position in the window wins.
        for (int j = 2*MAX_NI-1; j >= 1; j--) begin
            if (j >= lo_bound && j <= hi_bound && dbl[j[DBL_W-1:0]]) begin
                r.found = 1'b1;
                r.index = (j >= n) ? IDX_W'(j - n) : IDX_W'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ct_rr_arb.sv
// Combinational round-robin arbiter: picks the next requester after i_last.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller gates the grant with its own enable.
module ct_rr_arb
    import ct_merge_pkg::*;
#(
    parameter int NI    = 2,
    parameter int SRC_W = $clog2(NI)
) (
    input  logic [NI-1:0]    i_valid,
    input  logic [SRC_W-1:0] i_last,
    output logic             o_grant_valid,
    output logic [SRC_W-1:0] o_grant_idx
);

    logic [MAX_NI-1:0] valid_ext;
    logic [IDX_W-1:0]  last_ext;
    rr_pick_t          pick;

    // Widen the inputs to the helper's fixed width and narrow the result back.
    always_comb begin
        valid_ext           = '0;
        valid_ext[NI-1:0]   = i_valid;
        last_ext            = '0;
        last_ext[SRC_W-1:0] = i_last;
        pick                = rr_pick(valid_ext, last_ext, NI);
        o_grant_valid       = pick.found;
        o_grant_idx         = SRC_W'(pick.index);
    end

endmodule

// File: rtl/ct_rr_merge.sv
// Packet-aware round-robin merge of NI valid/ready streams onto one link.
// Latency: 1 cycle from accept to o_valid (single registered output stage).
// Backpressure: no skid; all o_ready drop while o_valid=1 and i_ready=0.
module ct_rr_merge
    import ct_merge_pkg::*;
#(
    parameter int NI    = 2,
    parameter int WIDTH = 8,
    parameter int SRC_W = $clog2(NI)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NI*WIDTH-1:0] i_data,
    input  logic [NI-1:0]       i_eop,
    input  logic [NI-1:0]       i_valid,
    output logic [NI-1:0]       o_ready,
    output logic [WIDTH-1:0]    o_data,
    output logic                o_eop,
    output logic [SRC_W-1:0]    o_src,
    output logic                o_valid,
    input  logic                i_ready
);

    merge_state_t     state;
    logic [SRC_W-1:0] held;
    logic [SRC_W-1:0] last;

    logic             arb_vld;
    logic [SRC_W-1:0] arb_idx;
    logic             grant_valid;
    logic [SRC_W-1:0] grant;
    logic             en;
    logic [NI-1:0]    rdy;
    logic             xfer;
    logic [WIDTH-1:0] beat_data;
    logic             beat_eop;

    // The output register can take a new beat when empty or being drained.
    assign en = !o_valid || i_ready;

    ct_rr_arb #(
        .NI    (NI),
        .SRC_W (SRC_W)
    ) u_arb (
        .i_valid       (i_valid),
        .i_last        (last),
        .o_grant_valid (arb_vld),
        .o_grant_idx   (arb_idx)
    );

    // Mid-packet the owner keeps the grant even if it has dropped valid.
    always_comb begin
        if (state == ST_LOCKED) begin
            grant_valid = 1'b1;
            grant       = held;
        end else begin
            grant_valid = arb_vld;
            grant       = arb_idx;
        end
    end

    // Steer the granted port's beat and raise only its ready.
    always_comb begin
        rdy       = '0;
        beat_data = '0;
        beat_eop  = 1'b0;
        for (int k = 0; k < NI; k++) begin
            if (grant == SRC_W'(k)) begin
                beat_data = i_data[k*WIDTH +: WIDTH];
                beat_eop  = i_eop[k];
                if (en && grant_valid && !i_reset) begin
                    rdy[k] = 1'b1;
                end
            end
        end
        xfer = |(i_valid & rdy);
    end

    assign o_ready = rdy;

    // Output stage: load on transfer, empty when enabled without one, else hold.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_eop   <= 1'b0;
            o_src   <= '0;
        end else if (en) begin
            o_valid <= xfer;
            if (xfer) begin
                o_data <= beat_data;
                o_eop  <= beat_eop;
                o_src  <= grant;
            end
        end
    end

    // Packet lock and fairness pointer; only a transfer moves them.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
            held  <= '0;
            last  <= SRC_W'(NI - 1);
        end else if (xfer) begin
            if (beat_eop) begin
                state <= ST_IDLE;
                last  <= grant;
            end else begin
                state <= ST_LOCKED;
                held  <= grant;
            end
        end
    end

endmodule

// File: tb/tb_ct_rr_merge.sv
// Self-checking bench for ct_rr_merge (NI=4): directed table, corner
// sequences, then randomized traffic against a packet-level reference model.
module tb_ct_rr_merge;

    localparam int NI = 4;
    localparam int W  = 8;

    logic          i_clk;
    logic          i_reset;
    logic [31:0]   i_data;
    logic [3:0]    i_eop;
    logic [3:0]    i_valid;
    logic [3:0]    o_ready;
    logic [7:0]    o_data;
    logic          o_eop;
    logic [1:0]    o_src;
    logic          o_valid;
    logic          i_ready;

    int total = 0;
    int bad   = 0;

    ct_rr_merge #(.NI(NI), .WIDTH(W), .SRC_W(2)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_data  (i_data),
        .i_eop   (i_eop),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_eop   (o_eop),
        .o_src   (o_src),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [3:0]  valid;
        logic [3:0]  eop;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  ordy;
        logic        ov;
        logic [7:0]  od;
        logic [1:0]  src;
        logic        oe;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] s;
        logic       e;
    } beat_t;

    vec_t  vecs[$];
    beat_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] eop,
                                input logic [31:0] data, input logic rdy,
                                input logic [3:0] ordy, input logic ov,
                                input logic [7:0] od, input logic [1:0] src,
                                input logic oe);
        vec_t v;
        v.valid = valid; v.eop = eop; v.data = data; v.rdy = rdy;
        v.ordy = ordy; v.ov = ov; v.od = od; v.src = src; v.oe = oe;
        return v;
    endfunction

    // Random-phase requester and model state.
    logic pres[4];
    int   rem[4];
    int   seq[4];
    int   m_last, m_owner, open_src, g;
    logic m_ov, en_m, acc;
    logic [3:0] exp_rdy;
    beat_t b;

    initial begin
        // ---- reset ----
        i_reset = 1'b1;
        i_valid = 4'hF;
        i_eop   = 4'h0;
        i_data  = '0;
        i_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ovalid", {31'd0, o_valid}, 32'd0);
        chk("rst_oready", {28'd0, o_ready}, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        i_valid = 4'h0;

        // ---- directed table: valid, eop, data, rdy | ordy, ov, od, src, oe ----
        // single requester 3-beat packet on port 0
        vecs.push_back(mk(4'b0001, 4'b0000, 32'h000000A1, 1, 4'b0001, 1, 8'hA1, 0, 0));
        vecs.push_back(mk(4'b0001, 4'b0000, 32'h000000A2, 1, 4'b0001, 1, 8'hA2, 0, 0));
        vecs.push_back(mk(4'b0001, 4'b0001, 32'h000000A3, 1, 4'b0001, 1, 8'hA3, 0, 1));
        vecs.push_back(mk(4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h00, 0, 0));
        // contention ports 0/1 (last=0 so port 1 first), no interleave
        vecs.push_back(mk(4'b0011, 4'b0000, 32'h0000C1B1, 1, 4'b0010, 1, 8'hC1, 1, 0));
        vecs.push_back(mk(4'b0011, 4'b0010, 32'h0000C2B1, 1, 4'b0010, 1, 8'hC2, 1, 1));
        vecs.push_back(mk(4'b0001, 4'b0000, 32'h000000B1, 1, 4'b0001, 1, 8'hB1, 0, 0));
        vecs.push_back(mk(4'b0001, 4'b0001, 32'h000000B2, 1, 4'b0001, 1, 8'hB2, 0, 1));
        // lock under starvation: port 1 drops valid mid-packet, port 0 starves
        vecs.push_back(mk(4'b0011, 4'b0000, 32'h0000E1D1, 1, 4'b0010, 1, 8'hE1, 1, 0));
        vecs.push_back(mk(4'b0001, 4'b0000, 32'h000000D1, 1, 4'b0010, 0, 8'h00, 0, 0));
        vecs.push_back(mk(4'b0001, 4'b0000, 32'h000000D1, 1, 4'b0010, 0, 8'h00, 0, 0));
        vecs.push_back(mk(4'b0011, 4'b0010, 32'h0000E2D1, 1, 4'b0010, 1, 8'hE2, 1, 1));
        vecs.push_back(mk(4'b0001, 4'b0000, 32'h000000D1, 1, 4'b0001, 1, 8'hD1, 0, 0));
        vecs.push_back(mk(4'b0001, 4'b0001, 32'h000000D2, 1, 4'b0001, 1, 8'hD2, 0, 1));
        // backpressure: 3 stalled cycles hold F1, then G1 goes through
        vecs.push_back(mk(4'b0100, 4'b0100, 32'h00F10000, 1, 4'b0100, 1, 8'hF1, 2, 1));
        vecs.push_back(mk(4'b1000, 4'b1000, 32'h71000000, 0, 4'b0000, 1, 8'hF1, 2, 1));
        vecs.push_back(mk(4'b1000, 4'b1000, 32'h71000000, 0, 4'b0000, 1, 8'hF1, 2, 1));
        vecs.push_back(mk(4'b1000, 4'b1000, 32'h71000000, 0, 4'b0000, 1, 8'hF1, 2, 1));
        vecs.push_back(mk(4'b1000, 4'b1000, 32'h71000000, 1, 4'b1000, 1, 8'h71, 3, 1));
        vecs.push_back(mk(4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h00, 0, 0));

        foreach (vecs[i]) begin
            @(negedge i_clk);
            i_valid = vecs[i].valid;
            i_eop   = vecs[i].eop;
            i_data  = vecs[i].data;
            i_ready = vecs[i].rdy;
            #1;
            chk($sformatf("tbl%0d_oready", i), {28'd0, o_ready}, {28'd0, vecs[i].ordy});
            @(posedge i_clk);
            #1;
            chk($sformatf("tbl%0d_ovalid", i), {31'd0, o_valid}, {31'd0, vecs[i].ov});
            if (vecs[i].ov) begin
                chk($sformatf("tbl%0d_odata", i), {24'd0, o_data}, {24'd0, vecs[i].od});
                chk($sformatf("tbl%0d_osrc", i), {30'd0, o_src}, {30'd0, vecs[i].src});
                chk($sformatf("tbl%0d_oeop", i), {31'd0, o_eop}, {31'd0, vecs[i].oe});
            end
        end

        // ---- wrap/fairness: all ports valid, single-beat packets ----
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            i_valid = 4'hF;
            i_eop   = 4'hF;
            i_data  = 32'h13121110;
            i_ready = 1'b1;
            @(posedge i_clk);
            #1;
            chk($sformatf("wrap%0d_src", i), {30'd0, o_src}, i % 4);
            chk($sformatf("wrap%0d_data", i), {24'd0, o_data}, 32'h10 + (i % 4));
        end
        @(negedge i_clk);
        i_valid = 4'h0;
        i_eop   = 4'h0;
        @(posedge i_clk);

        // ---- async reset mid-packet (last=1, port 2 starts a packet) ----
        @(negedge i_clk);
        i_valid = 4'b0100;
        i_eop   = 4'b0000;
        i_data  = 32'h005A0000;
        @(posedge i_clk);
        #1;
        chk("mp_ovalid_pre", {31'd0, o_valid}, 32'd1);
        #2;
        i_reset = 1'b1;
        #1;
        chk("mp_ovalid_rst", {31'd0, o_valid}, 32'd0);
        chk("mp_oready_rst", {28'd0, o_ready}, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        i_valid = 4'hF;
        i_eop   = 4'hF;
        #1;
        chk("mp_first_grant", {28'd0, o_ready}, 32'b0001);
        chk("mp_ovalid_post", {31'd0, o_valid}, 32'd0);
        i_valid = 4'h0;
        i_eop   = 4'h0;

        // ---- randomized traffic vs packet-level reference model ----
        m_last = 3; m_owner = -1; m_ov = 1'b0; open_src = -1;
        for (int p = 0; p < 4; p++) begin
            pres[p] = 1'b0; rem[p] = 0; seq[p] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge i_clk);
            for (int p = 0; p < 4; p++) begin
                if (!pres[p] && $urandom_range(0, 1) == 1) begin
                    if (rem[p] == 0) rem[p] = $urandom_range(1, 3);
                    pres[p] = 1'b1;
                end
                i_valid[p]        = pres[p];
                i_eop[p]          = (rem[p] == 1);
                i_data[p*8 +: 8]  = {2'(p), 6'(seq[p])};
            end
            i_ready = ($urandom_range(0, 3) != 0);
            #1;
            en_m = !m_ov || i_ready;
            g    = -1;
            if (m_owner >= 0) begin
                g = m_owner;
            end else begin
                for (int i = 1; i <= 4; i++) begin
                    int q;
                    q = (m_last + i) % 4;
                    if (g < 0 && i_valid[q[1:0]]) g = q;
                end
            end
            exp_rdy = (en_m && g >= 0) ? 4'(1 << g) : 4'b0000;
            chk("rnd_oready", {28'd0, o_ready}, {28'd0, exp_rdy});
            chk("rnd_ovalid", {31'd0, o_valid}, {31'd0, m_ov});
            if (m_ov && i_ready) begin
                b = exp_q.pop_front();
                chk("rnd_odata", {24'd0, o_data}, {24'd0, b.d});
                chk("rnd_osrc", {30'd0, o_src}, {30'd0, b.s});
                chk("rnd_oeop", {31'd0, o_eop}, {31'd0, b.e});
                if (open_src >= 0) chk("rnd_pkt_src", {30'd0, o_src}, open_src);
                open_src = b.e ? -1 : int'(b.s);
            end
            acc = en_m && (g >= 0) && i_valid[g[1:0]];
            if (acc) begin
                exp_q.push_back({i_data[g*8 +: 8], g[1:0], i_eop[g[1:0]]});
                if (i_eop[g[1:0]]) begin
                    m_owner = -1;
                    m_last  = g;
                end else begin
                    m_owner = g;
                end
                pres[g] = 1'b0;
                rem[g]  = rem[g] - 1;
                seq[g]  = seq[g] + 1;
            end
            if (en_m) m_ov = acc;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ct_rr_merge.md
Name: ct_rr_merge

Overview:
- Packet-aware round-robin arbiter/merger: shares one valid/ready output stream among NI requesters.
- Same valid/ready handshake semantics as the ct pipe stages; typically placed upstream of a ct_pipe_stage on a shared link.
- Grant is locked from a packet's first accepted beat through its EOP beat, so packets never interleave.
- Output data path is registered (one stage).

Parameters:
- NI, 2, number of requesters (>= 2).
- WIDTH, 8, data width per beat.
- SRC_W, $clog2(NI), width of the source-index output.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous active-high reset.
- i_data  in  NI*WIDTH  requester data; port k occupies bits [k*WIDTH +: WIDTH].
- i_eop  in  NI  end-of-packet flag per requester.
- i_valid  in  NI  per-requester valid.
- o_ready  out  NI  per-requester ready, one-hot or zero.
- o_data  out  WIDTH  merged data (registered).
- o_eop  out  1  merged end-of-packet (registered).
- o_src  out  SRC_W  index of the requester that produced the beat (registered).
- o_valid  out  1  merged valid (registered).
- i_ready  in  1  downstream ready.

Behaviour:
- Reset (async, i_reset=1): o_valid=0, state=IDLE, last=NI-1, held=0. o_data, o_eop and o_src are don't-care. o_ready=0 while reset is asserted.
- Output enable: en = !o_valid || i_ready. This is a single register, no skid buffer. Throughput is 1 beat/cycle while i_ready=1.
- Transfer on port k: i_valid[k] && o_ready[k].
  - At the clock edge, o_data/o_eop/o_src load the beat and o_valid becomes 1. Latency is exactly 1 cycle.
  - If en=1 and no transfer occurs, o_valid becomes 0.
  - If en=0, the output registers hold.
- Grant, combinational:
  - IDLE: g = first k with i_valid[k]=1, searching last+1, last+2, ... modulo NI. No valid input means no grant.
  - LOCKED: g = held, regardless of other valids.
- o_ready[k] = en && grant_valid && (g==k). In IDLE this depends on i_valid; that is intended. In LOCKED, o_ready[held]=en, independent of i_valid[held].
- State transitions (evaluated only on a transfer):
  - IDLE, beat with eop=0 -> LOCKED, held <= g.
  - IDLE, beat with eop=1 (single-beat packet) -> stay IDLE, last <= g.
  - LOCKED, beat with eop=1 -> IDLE, last <= held.
  - LOCKED, beat with eop=0 -> stay LOCKED.
  - No transfer: state, held and last are unchanged. This includes a locked requester dropping valid mid-packet: the lock holds and other requesters starve until EOP.
- Fairness: last updates only at packet end. After port k finishes a packet, port k has the lowest priority for the next packet.
- Wrap-around: the search from last=NI-1 starts at port 0. Implement as a rotate/double-width priority encode; no division.
- Simultaneous events are fine in one cycle: downstream pop (i_ready with o_valid) plus a new transfer in the same cycle.
- Reset mid-packet: the lock is discarded and the in-flight output beat is dropped. Upstream must reset with the block.
- Requesters must hold i_valid, data and eop stable until accepted. Violations are undefined.

Decomposition:
- Package ct_merge_pkg:
  - typedef enum logic {ST_IDLE, ST_LOCKED} merge_state_t;
  - function rr_pick(valid, last) returning {found, index}.
- Sub-module ct_rr_arb (parameter NI):
  - Purely combinational round-robin pick from i_valid and i_last.
  - Outputs o_grant_valid and o_grant_idx.
  - Reused by other shared-resource arbiters.
- Top module holds state, held, last and the output registers.

Test Plan:
- Single requester: NI=2, port 0 sends 3-beat packet A1,A2,A3(eop) with i_ready=1 -> o_data A1,A2,A3 on consecutive cycles starting 1 cycle after the first accept, o_src=0, o_eop only on A3.
- Contention: ports 0 and 1 both valid from reset (last=1), each with a 2-beat packet -> output order is port 0 packet then port 1 packet, no interleave, o_src 0,0,1,1.
- Lock under starvation: port 1 drops valid for 2 cycles mid-packet while port 0 is valid -> o_ready[0] stays 0, port 1 resumes, its EOP completes, then port 0 is granted.
- Backpressure: i_ready=0 for 3 cycles while o_valid=1 -> o_data stable, o_ready all 0; i_ready=1 resumes with no beat lost or duplicated.
- Wrap/fairness: NI=4, all ports continuously valid with single-beat packets -> o_src sequence 0,1,2,3,0,1; scoreboard checks beat order per source.
- Async reset asserted mid-packet -> o_valid=0 immediately, state=IDLE; after release, port 0 is granted first.
